// File: rtl/fetcher_icache_pkg.sv
// ============================================================================
// Module : fetcher_icache_pkg
// Brief  : Shared scheduler/fetcher state encodings for the core pipeline.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fetcher_icache_pkg;

  typedef enum logic [2:0] {
    CORE_IDLE    = 3'b000,
    CORE_FETCH   = 3'b001,
    CORE_DECODE  = 3'b010,
    CORE_REQUEST = 3'b011,
    CORE_WAIT    = 3'b100,
    CORE_EXECUTE = 3'b101,
    CORE_UPDATE  = 3'b110,
    CORE_DONE    = 3'b111
  } corestate_t;

  typedef enum logic [2:0] {
    FETCHER_IDLE     = 3'b000,
    FETCHER_FETCHING = 3'b001,
    FETCHER_FETCHED  = 3'b010,
    FETCHER_LOOKUP   = 3'b011
  } fetcher_state_t;

endpackage

`default_nettype wire

// File: rtl/icache_array.sv
// ============================================================================
// Module : icache_array
// Brief  : Direct-mapped tag/valid/data store, one instruction per line.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module icache_array #(
  parameter int ADDR_BITS  = 8,
  parameter int DATA_BITS  = 16,
  parameter int INDEX_BITS = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic                 rd_hit,
  output logic [DATA_BITS-1:0] rd_data,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 flush
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = ADDR_BITS - INDEX_BITS;

  logic [LINES-1:0]     r_valid;
  logic [TAG_BITS-1:0]  r_tag  [LINES];
  logic [DATA_BITS-1:0] r_data [LINES];

  logic [INDEX_BITS-1:0] w_rd_index;
  logic [INDEX_BITS-1:0] w_wr_index;

  assign w_rd_index = rd_addr[INDEX_BITS-1:0];
  assign w_wr_index = wr_addr[INDEX_BITS-1:0];

  assign rd_hit  = r_valid[w_rd_index] &&
                   (r_tag[w_rd_index] == rd_addr[ADDR_BITS-1:INDEX_BITS]);
  assign rd_data = r_data[w_rd_index];

  // Flush has priority so a fill landing on the same edge stays invalid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
    end else if (flush) begin
      r_valid <= '0;
    end else if (wr_en) begin
      r_valid[w_wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_tag[w_wr_index]  <= wr_addr[ADDR_BITS-1:INDEX_BITS];
      r_data[w_wr_index] <= wr_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetcher_icache.sv
// ============================================================================
// Module : fetcher_icache
// Brief  : Per-core instruction fetcher with a shared direct-mapped I-cache.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetcher_icache
  import fetcher_icache_pkg::*;
#(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16,
  parameter int CACHE_INDEX_BITS      = 3,
  parameter int COUNTER_BITS          = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  corestate_t                       core_state,
  input  logic                             warp_select,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             cache_flush,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic                             fetched_warp,
  output logic [COUNTER_BITS-1:0]          hit_count,
  output logic [COUNTER_BITS-1:0]          miss_count
);

  fetcher_state_t r_state;
  fetcher_state_t w_next_state;

  logic [PROGRAM_MEM_ADDR_BITS-1:0] r_pc;
  logic                             w_array_hit;
  logic [PROGRAM_MEM_DATA_BITS-1:0] w_array_data;
  logic                             w_lookup_hit;
  logic                             w_fill;

  icache_array #(
    .ADDR_BITS  (PROGRAM_MEM_ADDR_BITS),
    .DATA_BITS  (PROGRAM_MEM_DATA_BITS),
    .INDEX_BITS (CACHE_INDEX_BITS)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .rd_addr (r_pc),
    .rd_hit  (w_array_hit),
    .rd_data (w_array_data),
    .wr_en   (w_fill),
    .wr_addr (mem_read_address),
    .wr_data (mem_read_data),
    .flush   (cache_flush)
  );

  // A flush coinciding with the lookup must not return a line it is killing.
  assign w_lookup_hit  = w_array_hit && !cache_flush;
  assign w_fill        = (r_state == FETCHER_FETCHING) && mem_read_valid && mem_read_ready;
  assign fetcher_state = r_state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= FETCHER_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      FETCHER_IDLE: begin
        if (core_state == CORE_FETCH) w_next_state = FETCHER_LOOKUP;
      end
      FETCHER_LOOKUP: begin
        w_next_state = w_lookup_hit ? FETCHER_FETCHED : FETCHER_FETCHING;
      end
      FETCHER_FETCHING: begin
        if (w_fill) w_next_state = FETCHER_FETCHED;
      end
      FETCHER_FETCHED: begin
        if (core_state == CORE_DECODE || core_state == CORE_IDLE) w_next_state = FETCHER_IDLE;
      end
      default: w_next_state = FETCHER_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc             <= '0;
      fetched_warp     <= 1'b0;
      instruction      <= '0;
      mem_read_valid   <= 1'b0;
      mem_read_address <= '0;
      hit_count        <= '0;
      miss_count       <= '0;
    end else begin
      case (r_state)
        FETCHER_IDLE: begin
          if (core_state == CORE_FETCH) begin
            r_pc         <= current_pc;
            fetched_warp <= warp_select;
          end
        end
        FETCHER_LOOKUP: begin
          if (w_lookup_hit) begin
            instruction <= w_array_data;
            if (hit_count != '1) hit_count <= hit_count + 1'b1;
          end else begin
            mem_read_valid   <= 1'b1;
            mem_read_address <= r_pc;
            if (miss_count != '1) miss_count <= miss_count + 1'b1;
          end
        end
        FETCHER_FETCHING: begin
          if (w_fill) begin
            instruction    <= mem_read_data;
            mem_read_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/fetcher_icache.md
Name: fetcher_icache

Overview:
Per-core instruction fetcher, the responder to the scheduler's CORE_FETCH request. When the core enters CORE_FETCH it looks the current PC up in a small direct-mapped instruction cache. On a miss it runs a valid/ready read to program memory. It then reports FETCHED (3'b010) on fetcher_state so the scheduler can advance to CORE_DECODE. The cache is shared by both warps and tagged by PC only, because all warps execute the same program.

Parameters:
PROGRAM_MEM_ADDR_BITS, 8, program address / PC width
PROGRAM_MEM_DATA_BITS, 16, instruction width
CACHE_INDEX_BITS, 3, log2 of cache lines (8 lines, one instruction per line)
COUNTER_BITS, 16, width of the hit and miss statistics counters

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
core_state  in  corestate_t  scheduler state
warp_select  in  1  active warp, sampled at request acceptance
current_pc  in  ADDR  PC to fetch
cache_flush  in  1  invalidate all lines (kernel launch)
mem_read_valid  out  1  program-memory read request
mem_read_address  out  ADDR  request address
mem_read_ready  in  1  memory response strobe; data valid this cycle
mem_read_data  in  DATA  returned instruction
fetcher_state  out  3  IDLE=000, FETCHING=001, FETCHED=010, LOOKUP=011
instruction  out  DATA  fetched instruction, stable while FETCHED
fetched_warp  out  1  warp_select latched at acceptance
hit_count  out  COUNTER_BITS  saturating lookup-hit count
miss_count  out  COUNTER_BITS  saturating lookup-miss count

Behaviour:
- Reset (reset==0, asynchronous): the FSM goes to IDLE and all outputs go to 0. All valid bits clear and both counters clear. Tag/data storage need not be reset.
- IDLE: if core_state==CORE_FETCH, latch current_pc and warp_select (the latter into fetched_warp), then go to LOOKUP. Otherwise stay in IDLE.
- LOOKUP (exactly 1 cycle): index = pc[CACHE_INDEX_BITS-1:0]; tag = remaining upper PC bits.
  - Hit (valid, tag match, and cache_flush==0): instruction <= line data, go to FETCHED, hit_count++.
  - Otherwise it is a miss: mem_read_valid <= 1, mem_read_address <= pc, go to FETCHING, miss_count++.
  - cache_flush asserted during LOOKUP forces a miss.
- FETCHING: mem_read_valid and mem_read_address stay stable until the cycle in which mem_read_ready==1.
  - In that cycle: instruction <= mem_read_data, the line is written (tag, data, valid=1), mem_read_valid <= 0, go to FETCHED.
  - ready is ignored whenever mem_read_valid==0.
- FETCHED: instruction and fetched_warp are held.
  - core_state==CORE_DECODE: go to IDLE; instruction keeps its value.
  - core_state==CORE_IDLE (abort): go to IDLE.
  - Any other core_state: hold FETCHED.
- Latency, with the CORE_FETCH edge at cycle 0:
  - Hit: LOOKUP at cycle 1, FETCHED at cycle 2.
  - Miss: FETCHING and mem_read_valid from cycle 2; ready at cycle k gives FETCHED at k+1.
- An in-flight memory request is never abandoned. core_state changes during FETCHING are ignored until the fill completes.
- cache_flush: all valid bits clear on the next edge, in any state.
  - If flush coincides with the fill cycle, the line's valid bit stays 0 (flush wins). The instruction is still delivered.
- Counters saturate at all-ones and never wrap. The counters are not cleared by cache_flush.
- A fill and a lookup never occur in the same cycle (single outstanding access).

Decomposition:
- enums.svh (shared package) holds the fetcher_state_t enum (FETCHER_IDLE, FETCHER_FETCHING, FETCHER_FETCHED=3'b010, FETCHER_LOOKUP), next to corestate_t.
- Sub-module icache_array owns the tag/valid/data arrays. It has:
  - a combinational read: index → hit, data
  - a single write port: index, tag, data, en
  - a flush input
  - the same asynchronous active-low reset, which clears the valid bits
- fetcher_icache holds the FSM, request registers and counters.

Test Plan:
- Cold miss: after reset, CORE_FETCH with pc=0x05; memory returns 0x1234 three cycles after valid → mem_read_address=0x05 held stable, FETCHED with instruction=0x1234, miss_count=1, hit_count=0.
- Warm hit: repeat pc=0x05 after CORE_DECODE → no mem_read_valid, FETCHED exactly 2 cycles after CORE_FETCH, instruction=0x1234, hit_count=1.
- Conflict: pc=0x05 then 0x0D (same index, different tag; memory returns 0xBEEF) then 0x05 → miss, miss, miss; miss_count=3, instruction=0xBEEF on the 0x0D fetch.
- Flush: cache_flush asserted for 1 cycle after the 0x05 fill, then fetch pc=0x05 → miss and memory request issued. Separately, flush pulsed in the exact fill cycle → that instruction is delivered but the next fetch of the same PC misses.
- Abort/reset: core_state forced to CORE_IDLE during FETCHING → request held until ready, then FETCHED, then IDLE when CORE_IDLE is seen. reset=0 mid-FETCHING → mem_read_valid=0 and fetcher_state=000 immediately (asynchronous), and a subsequent fetch misses.
- Warp and saturation: warp_select=1 at acceptance → fetched_warp=1 through FETCHED. Preloading hit_count=0xFFFF (COUNTER_BITS=16) and then hitting → it stays at 0xFFFF.
